// File: rtl/impact_head_pkg.sv
// Shared constants for the IMPACT head controller: register map, FSM states, STATUS layout.
// Optional operation counter is controlled by IMPACT_HEAD_CTRL_OPCNT_EN (see impact_head_ctrl).
package impact_head_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_SOUTH  = 2'd1;
  localparam logic [1:0] REG_WEST   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_LAST      = 2;
  localparam int STAT_OPCNT_LSB = 16;
  localparam int STAT_CLR_OPCNT = 31;

endpackage

// File: rtl/impact_rr_arb2.sv
// Two-way round-robin arbiter (WB vs pad) with a last-grant register that resets to pad,
// so the first tie goes to WB.
module impact_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_wb,
  input  logic req_pad,
  output logic gnt_wb,
  output logic gnt_pad,
  output logic last_pad_o
);

  logic last_pad_q, last_pad_d;

  // On a tie the requester that was not served last wins.
  assign gnt_wb  = en & req_wb  & (~req_pad | last_pad_q);
  assign gnt_pad = en & req_pad & (~req_wb  | ~last_pad_q);

  always_comb begin
    last_pad_d = last_pad_q;
    if (gnt_pad)     last_pad_d = 1'b1;
    else if (gnt_wb) last_pad_d = 1'b0;
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) last_pad_q <= 1'b1;
    else     last_pad_q <= last_pad_d;
  end

  assign last_pad_o = last_pad_q;

endmodule

// File: rtl/impact_head_ctrl.sv
// Sequencer/arbiter for the IMPACT head: grants WB or pad operand onto East, waits SETTLE_CYCLES,
// captures South/West and pulses irq_o. `define IMPACT_HEAD_CTRL_OPCNT_EN adds STATUS[31:16] op counter.
module impact_head_ctrl #(
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter int          SETTLE_CYCLES = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        pad_valid_i,
  input  logic [31:0] pad_data_i,
  output logic        pad_ready_o,
  output logic [31:0] east_o,
  input  logic [31:0] south_i,
  input  logic [31:0] west_i,
  output logic        irq_o
);

  import impact_head_pkg::*;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] east_q, east_d;
  logic [31:0] south_q, south_d;
  logic [31:0] west_q, west_d;
  logic        done_q, done_d;
  logic        have_grant_q, have_grant_d;
  logic        irq_q, irq_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;

  logic        wb_hit, data_wr, other_acc, wr_status;
  logic        gnt_wb, gnt_pad, last_pad;
  logic [1:0]  reg_idx;
  logic [31:0] status_w, rdata;

  // Byte lanes and the low address bits carry no information for full-word registers.
  logic unused_ok;
  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

  assign reg_idx   = wbs_adr_i[3:2];
  assign wb_hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign data_wr   = wb_hit & wbs_we_i & (reg_idx == REG_DATA);
  // ack_q masks the second cycle of a classic cycle so each access acks exactly once.
  assign other_acc = wb_hit & ~data_wr & ~ack_q;
  assign wr_status = other_acc & wbs_we_i & (reg_idx == REG_STATUS);

  impact_rr_arb2 u_arb (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .en         (state_q == ST_IDLE),
    .req_wb     (data_wr & ~ack_q),
    .req_pad    (pad_valid_i),
    .gnt_wb     (gnt_wb),
    .gnt_pad    (gnt_pad),
    .last_pad_o (last_pad)
  );

`ifdef IMPACT_HEAD_CTRL_OPCNT_EN
  logic [15:0] opcnt_q, opcnt_d;

  always_comb begin
    opcnt_d = opcnt_q;
    if (wr_status && wbs_dat_i[STAT_CLR_OPCNT]) opcnt_d = '0;
    if (state_q == ST_CAPTURE)                  opcnt_d = opcnt_q + 16'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) opcnt_q <= '0;
    else          opcnt_q <= opcnt_d;
  end
`endif

  // Last-grant reads 0 until something has actually been granted, so STATUS is 0 out of reset.
  always_comb begin
    status_w                = '0;
    status_w[STAT_BUSY]     = (state_q != ST_IDLE);
    status_w[STAT_DONE]     = done_q;
    status_w[STAT_LAST]     = last_pad & have_grant_q;
`ifdef IMPACT_HEAD_CTRL_OPCNT_EN
    status_w[31:STAT_OPCNT_LSB] = opcnt_q;
`endif
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_DATA:   rdata = east_q;
      REG_SOUTH:  rdata = south_q;
      REG_WEST:   rdata = west_q;
      REG_STATUS: rdata = status_w;
      default:    rdata = '0;
    endcase
  end

  // NOTE: every next-state value starts from its current value, so no latch can be inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    east_d       = east_q;
    south_d      = south_q;
    west_d       = west_q;
    done_d       = done_q;
    have_grant_d = have_grant_q | gnt_wb | gnt_pad;
    irq_d        = 1'b0;
    ack_d        = gnt_wb | other_acc;
    dat_d        = '0;

    if (other_acc && !wbs_we_i) dat_d = rdata;

    case (state_q)
      ST_IDLE: begin
        if (gnt_wb) begin
          east_d  = wbs_dat_i;
          cnt_d   = SETTLE_INIT;
          state_d = ST_SETTLE;
        end else if (gnt_pad) begin
          east_d  = pad_data_i;
          cnt_d   = SETTLE_INIT;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 8'd0) state_d = ST_CAPTURE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_CAPTURE: begin
        south_d = south_i;
        west_d  = west_i;
        irq_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Capture sets done after the clear so a simultaneous set wins.
    if (wr_status && wbs_dat_i[STAT_DONE]) done_d = 1'b0;
    if (state_q == ST_CAPTURE)             done_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      east_q       <= '0;
      south_q      <= '0;
      west_q       <= '0;
      done_q       <= 1'b0;
      have_grant_q <= 1'b0;
      irq_q        <= 1'b0;
      ack_q        <= 1'b0;
      dat_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      east_q       <= east_d;
      south_q      <= south_d;
      west_q       <= west_d;
      done_q       <= done_d;
      have_grant_q <= have_grant_d;
      irq_q        <= irq_d;
      ack_q        <= ack_d;
      dat_q        <= dat_d;
    end
  end

  assign pad_ready_o = gnt_pad & ~wb_rst_i;
  assign east_o      = east_q;
  assign irq_o       = irq_q;
  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;

endmodule
